// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry skid-buffer pipeline register.
// Ports:
//   clk, reset (async, active-low), flush (sync discard)
//   in_valid/in_ready/in_pc/in_a3/in_data    : upstream beat
//   out_valid/out_ready/out_pc/out_a3/out_data : downstream beat
//   occupancy : number of beats held (0..2)
module pipe_stage_reg #(
    parameter int          DATA_W   = 32,
    parameter int          NUM_CH   = 7,
    parameter int          A3_W     = 5,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [A3_W-1:0]          in_a3,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [A3_W-1:0]          out_a3,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [1:0]               occupancy
);

    localparam int PW = NUM_CH * DATA_W;

    logic            main_v_q,    main_v_d;
    logic [31:0]     main_pc_q,   main_pc_d;
    logic [A3_W-1:0] main_a3_q,   main_a3_d;
    logic [PW-1:0]   main_data_q, main_data_d;
    logic            skid_v_q,    skid_v_d;
    logic [31:0]     skid_pc_q,   skid_pc_d;
    logic [A3_W-1:0] skid_a3_q,   skid_a3_d;
    logic [PW-1:0]   skid_data_q, skid_data_d;
    logic            rdy_q,       rdy_d;
    logic            acc;
    logic            cons;

    always_comb begin
        main_v_d    = main_v_q;
        main_pc_d   = main_pc_q;
        main_a3_d   = main_a3_q;
        main_data_d = main_data_q;
        skid_v_d    = skid_v_q;
        skid_pc_d   = skid_pc_q;
        skid_a3_d   = skid_a3_q;
        skid_data_d = skid_data_q;
        acc         = in_valid & rdy_q;
        cons        = main_v_q & out_ready;
        if (flush) begin
            main_v_d    = 1'b0;
            skid_v_d    = 1'b0;
            main_pc_d   = RESET_PC;
            main_a3_d   = '0;
            main_data_d = '0;
        end else if (!main_v_q || cons) begin
            // Skid holds the older beat, so it wins the refill.
            // in_ready is low whenever skid is full, so no accept
            // can collide with this move.
            if (skid_v_q) begin
                main_v_d    = 1'b1;
                main_pc_d   = skid_pc_q;
                main_a3_d   = skid_a3_q;
                main_data_d = skid_data_q;
                skid_v_d    = 1'b0;
            end else if (acc) begin
                main_v_d    = 1'b1;
                main_pc_d   = in_pc;
                main_a3_d   = in_a3;
                main_data_d = in_data;
            end else begin
                // Payload holds its last value; only valid drops.
                main_v_d = 1'b0;
            end
        end else if (acc) begin
            skid_v_d    = 1'b1;
            skid_pc_d   = in_pc;
            skid_a3_d   = in_a3;
            skid_data_d = in_data;
        end
        // Registered ready: no path from out_ready to in_ready.
        rdy_d = ~skid_v_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_v_q    <= 1'b0;
            main_pc_q   <= RESET_PC;
            main_a3_q   <= '0;
            main_data_q <= '0;
            skid_v_q    <= 1'b0;
            skid_pc_q   <= '0;
            skid_a3_q   <= '0;
            skid_data_q <= '0;
            rdy_q       <= 1'b1;
        end else begin
            main_v_q    <= main_v_d;
            main_pc_q   <= main_pc_d;
            main_a3_q   <= main_a3_d;
            main_data_q <= main_data_d;
            skid_v_q    <= skid_v_d;
            skid_pc_q   <= skid_pc_d;
            skid_a3_q   <= skid_a3_d;
            skid_data_q <= skid_data_d;
            rdy_q       <= rdy_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = main_v_q;
    assign out_pc    = main_pc_q;
    assign out_a3    = main_a3_q;
    assign out_data  = main_data_q;
    assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};

endmodule
